// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one decoder-based full-adder cell is time-shared
// LSB-first across all operand bits, with valid/ready handshakes on both sides.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);
    logic [7:0] m;

    // One-hot minterm decode of {a,b,cin}; sum and carry are ORs of minterms.
    always_comb begin
        m = 8'd0;
        m[{a, b, cin}] = 1'b1;
    end

    assign s  = m[1] | m[2] | m[4] | m[7];
    assign co = m[3] | m[5] | m[6] | m[7];
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE  = CW'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic             carry_q, c_msb;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_co;

    full_adder u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            carry_q   <= 1'b0;
            c_msb     <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry_q  <= cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    s_sh    <= {fa_s, s_sh[WIDTH-1:1]};
                    carry_q <= fa_co;
                    cnt     <= cnt + 1'b1;
                    // Carry produced by bit WIDTH-2 is the carry into the MSB.
                    if (cnt == PRE)
                        c_msb <= fa_co;
                    if (cnt == LAST) begin
                        sum       <= {fa_s, s_sh[WIDTH-1:1]};
                        cout      <= fa_co;
                        ovf       <= (WIDTH == 2 ? carry_q : c_msb) ^ fa_co;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed checks of serial_adder_ctrl at WIDTH=8 and WIDTH=16.

module tb_serial_adder_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
    logic [7:0]  a, b, sum;
    logic        iv16, ir16, cin16, ov16, or16, cout16, ovf16, busy16;
    logic [15:0] a16, b16, sum16;

    int cmp = 0;
    int err = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin16), .out_valid(ov16), .out_ready(or16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input logic [7:0] es, input logic ec, input logic eo,
                          input int hold, input string nm);
        int n, bn;
        logic ok;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        cmp++;
        if (in_ready !== 1'b1) begin
            err++; $display("FAIL %s in_ready: got %b want 1", nm, in_ready);
        end
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        n = 0; bn = 0;
        while (!out_valid && n < 40) begin
            if (busy) bn++;
            tick(); n++;
        end
        cmp++;
        if (n != 8 || out_valid !== 1'b1) begin
            err++; $display("FAIL %s latency: got %0d valid=%b want 8", nm, n, out_valid);
        end
        cmp++;
        if (bn != 8 || busy !== 1'b0) begin
            err++; $display("FAIL %s busy_cycles: got %0d (busy=%b) want 8", nm, bn, busy);
        end
        cmp++;
        if (sum !== es || cout !== ec || ovf !== eo) begin
            err++; $display("FAIL %s result: got %h/%b/%b want %h/%b/%b", nm, sum, cout, ovf, es, ec, eo);
        end
        if (hold > 0) begin
            ok = 1'b1;
            repeat (hold) begin
                tick();
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== es) ok = 1'b0;
            end
            cmp++;
            if (!ok) begin
                err++; $display("FAIL %s hold: got valid=%b sum=%h want 1/%h", nm, out_valid, sum, es);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== es) begin
            err++; $display("FAIL %s release: got valid=%b rdy=%b sum=%h want 0/1/%h", nm, out_valid, in_ready, sum, es);
        end
    endtask

    task automatic run_op16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                            input logic [15:0] es, input logic ec, input logic eo, input string nm);
        int n;
        n = 0;
        while (!ir16 && n < 50) begin tick(); n++; end
        a16 = ta; b16 = tb_; cin16 = tc; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        n = 0;
        while (!ov16 && n < 60) begin tick(); n++; end
        cmp++;
        if (n != 16 || ov16 !== 1'b1) begin
            err++; $display("FAIL %s latency16: got %0d want 16", nm, n);
        end
        cmp++;
        if (sum16 !== es || cout16 !== ec || ovf16 !== eo) begin
            err++; $display("FAIL %s result16: got %h/%b/%b want %h/%b/%b", nm, sum16, cout16, ovf16, es, ec, eo);
        end
        or16 = 1'b1;
        tick();
        or16 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
            err++; $display("FAIL reset_state: got rdy=%b vld=%b busy=%b sum=%h c=%b o=%b want 1/0/0/00/0/0",
                            in_ready, out_valid, busy, sum, cout, ovf);
        end
    endtask

    task automatic test_basic();
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, "ff_plus_01");
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, "7f_plus_01");
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, "80_plus_80");
        run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0, "cin_only");
    endtask

    task automatic test_backpressure();
        logic ok;
        a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
        tick();
        // Keep presenting junk operands through ADD and DONE; none may be taken.
        a = 8'hFF; b = 8'hFF;
        repeat (8) tick();
        cmp++;
        if (out_valid !== 1'b1 || sum !== 8'h46 || cout !== 1'b0 || ovf !== 1'b0) begin
            err++; $display("FAIL bp_result: got vld=%b sum=%h want 1/46", out_valid, sum);
        end
        ok = 1'b1;
        repeat (5) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 8'h46 || busy !== 1'b0) ok = 1'b0;
        end
        cmp++;
        if (!ok) begin
            err++; $display("FAIL bp_hold: got vld=%b rdy=%b sum=%h want 1/0/46", out_valid, in_ready, sum);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            err++; $display("FAIL bp_release: got vld=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        repeat (3) tick();
        cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'h46) begin
            err++; $display("FAIL bp_not_queued: got busy=%b vld=%b sum=%h want 0/0/46", busy, out_valid, sum);
        end
    endtask

    task automatic test_mid_reset();
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        cmp++;
        if (busy !== 1'b1) begin
            err++; $display("FAIL mid_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            err++; $display("FAIL mid_reset: got rdy=%b vld=%b busy=%b sum=%h want 1/0/0/00", in_ready, out_valid, busy, sum);
        end
        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 0, "b2b_0");
        run_op(8'h3C, 8'h44, 1'b0, 8'h80, 1'b0, 1'b1, 2, "b2b_1");
        run_op(8'hC8, 8'h9C, 1'b0, 8'h64, 1'b1, 1'b1, 1, "b2b_2");
        run_op(8'h01, 8'hFE, 1'b1, 8'h00, 1'b1, 1'b0, 0, "b2b_3");
        run_op(8'h55, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b1, 3, "b2b_4");
    endtask

    task automatic test_width16();
        run_op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "w16_0");
        run_op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "w16_1");
        run_op16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, "w16_2");
        run_op16(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, "w16_3");
        run_op16(16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0, "w16_4");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_width16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
